// File: rtl/mdu_iter.sv
// mdu_iter: iterative 32x32 multiply/divide unit producing HI/LO results.
// Optional macro MDU_FAST_MUL_EN selects a single-cycle multiplier path.
module mdu_iter (
   input  logic        clk,
   input  logic        rst,
   input  logic        Start,
   input  logic [2:0]  Op,
   input  logic [31:0] SrcA,
   input  logic [31:0] SrcB,
   input  logic        Cancel,
   output logic        Busy,
   output logic [1:0]  Signal,
   output logic [63:0] MUTAns
);

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      FIX,
      WRITE
   } state_t;

   state_t state, state_nx;

   logic [2:0]  op_q;
   logic [31:0] opa;
   logic [31:0] opb;
   logic        sa;
   logic        sb;
   logic [4:0]  cnt;
   logic [63:0] acc;
   logic [31:0] rem;

   logic        legal;
   logic        is_div_in;
   logic        is_sgn_in;
   logic        neg_a_in;
   logic        neg_b_in;
   logic [31:0] abs_a_in;
   logic [31:0] abs_b_in;
   logic        accept;
   logic        fast_go;
   logic [63:0] fast_res;

   assign legal     = (Op[2:1] != 2'b11);
   assign is_div_in = (Op[2:1] == 2'b01);
   assign is_sgn_in = ~Op[0];
   assign neg_a_in  = is_sgn_in & SrcA[31];
   assign neg_b_in  = is_sgn_in & SrcB[31];
   assign abs_a_in  = neg_a_in ? -SrcA : SrcA;
   assign abs_b_in  = neg_b_in ? -SrcB : SrcB;

   // Cancel in IDLE wins over Start
   assign accept = (state == IDLE) & Start & legal & ~Cancel;

`ifdef MDU_FAST_MUL_EN
   logic [63:0] fast_mag;
   assign fast_mag = {32'b0, abs_a_in} * {32'b0, abs_b_in};
   assign fast_go  = accept & ~is_div_in;
   assign fast_res = (neg_a_in ^ neg_b_in) ? -fast_mag : fast_mag;
`else
   assign fast_go  = 1'b0;
   assign fast_res = '0;
`endif

   assign Busy = (state != IDLE);

   // iteration datapath
   logic        is_div_q;
   logic [32:0] mul_sum;
   logic [32:0] shl;
   logic [31:0] dif;
   logic        ge;

   assign is_div_q = (op_q[2:1] == 2'b01);
   assign mul_sum  = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opa} : 33'd0);
   assign shl      = {rem, acc[31]};
   assign ge       = (shl >= {1'b0, opb});
   assign dif      = shl[31:0] - opb;

   // sign correction and divide-by-zero override
   logic [63:0] prod;
   logic [31:0] quo;
   logic [31:0] rmd;
   logic [31:0] a_raw;
   logic [63:0] fix_res;
   logic [1:0]  cmd_q;

   assign prod  = (sa ^ sb) ? -acc : acc;
   assign quo   = (sa ^ sb) ? -acc[31:0] : acc[31:0];
   assign rmd   = sa ? -rem : rem;
   assign a_raw = sa ? -opa : opa;
   assign cmd_q = op_q[2] ? 2'b10 : 2'b01;

   always_comb begin
      fix_res = prod;
      if (is_div_q) begin
         if (opb == 32'd0) fix_res = {a_raw, 32'hFFFF_FFFF};
         else              fix_res = {rmd, quo};
      end
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE: begin
            if (fast_go)     state_nx = WRITE;
            else if (accept) state_nx = CALC;
         end
         CALC: begin
            if (Cancel)           state_nx = IDLE;
            else if (cnt == 5'd0) state_nx = FIX;
         end
         FIX:     state_nx = Cancel ? IDLE : WRITE;
         WRITE:   state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nx;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         op_q   <= '0;
         opa    <= '0;
         opb    <= '0;
         sa     <= 1'b0;
         sb     <= 1'b0;
         cnt    <= '0;
         acc    <= '0;
         rem    <= '0;
         Signal <= 2'b00;
         MUTAns <= '0;
      end else begin
         Signal <= 2'b00;
         if (accept && !fast_go) begin
            op_q <= Op;
            sa   <= neg_a_in;
            sb   <= neg_b_in;
            opa  <= abs_a_in;
            opb  <= abs_b_in;
            cnt  <= 5'd31;
            rem  <= '0;
            // low half holds multiplier or dividend
            acc  <= {32'b0, is_div_in ? abs_a_in : abs_b_in};
         end
         if (state == CALC) begin
            if (cnt != 5'd0) cnt <= cnt - 5'd1;
            if (is_div_q) begin
               rem       <= ge ? dif : shl[31:0];
               acc[31:0] <= {acc[30:0], ge};
            end else begin
               acc <= {mul_sum, acc[31:1]};
            end
         end
         if (state == FIX && !Cancel) begin
            MUTAns <= fix_res;
            Signal <= cmd_q;
         end
         if (fast_go) begin
            MUTAns <= fast_res;
            Signal <= Op[2] ? 2'b10 : 2'b01;
         end
      end
   end

endmodule

// File: tb/tb_mdu_iter.sv
// tb_mdu_iter: randomized self-checking bench for mdu_iter.
// Results are checked against an arithmetic reference model.
module tb_mdu_iter;

   logic        clk;
   logic        rst;
   logic        Start;
   logic [2:0]  Op;
   logic [31:0] SrcA;
   logic [31:0] SrcB;
   logic        Cancel;
   logic        Busy;
   logic [1:0]  Signal;
   logic [63:0] MUTAns;

   int n_cmp = 0;
   int n_bad = 0;
   logic [63:0] exp_hold = '0;

   mdu_iter dut (
      .clk    (clk),
      .rst    (rst),
      .Start  (Start),
      .Op     (Op),
      .SrcA   (SrcA),
      .SrcB   (SrcB),
      .Cancel (Cancel),
      .Busy   (Busy),
      .Signal (Signal),
      .MUTAns (MUTAns)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] ref_ans(input logic [2:0] op,
                                           input logic [31:0] a,
                                           input logic [31:0] b);
      longint          xa, xb, q, m;
      longint unsigned ua, ub, uq, um;
      logic [63:0]     r;
      xa = longint'($signed(a));
      xb = longint'($signed(b));
      ua = {32'b0, a};
      ub = {32'b0, b};
      r  = '0;
      case (op)
         3'd0, 3'd4: r = xa * xb;
         3'd1, 3'd5: r = ua * ub;
         3'd2: begin
            if (b == 32'd0) r = {a, 32'hFFFF_FFFF};
            else begin
               q = xa / xb;
               m = xa % xb;
               r = {m[31:0], q[31:0]};
            end
         end
         3'd3: begin
            if (b == 32'd0) r = {a, 32'hFFFF_FFFF};
            else begin
               uq = ua / ub;
               um = ua % ub;
               r  = {um[31:0], uq[31:0]};
            end
         end
         default: r = '0;
      endcase
      return r;
   endfunction

   function automatic int lat(input logic [2:0] op);
`ifdef MDU_FAST_MUL_EN
      return (op[2:1] == 2'b01) ? 34 : 1;
`else
      return 34;
`endif
   endfunction

   // call right after a negedge
   task automatic run_op(input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input bit spam);
      logic [63:0] e;
      int n;
      int wr;
      e = ref_ans(op, a, b);
      Start = 1'b1;
      Op    = op;
      SrcA  = a;
      SrcB  = b;
      n = 0;
      while (1) begin
         @(negedge clk);
         n++;
         if (n == 1) chk("busy_on", Busy, 1);
         if (Signal != 2'b00 || n >= 60) break;
         if (spam) begin
            Start = 1'($urandom);
            Op    = 3'($urandom_range(0, 5));
            SrcA  = $urandom;
            SrcB  = $urandom;
         end else begin
            Start = 1'b0;
         end
      end
      Start = 1'b0;
      chk("latency", 64'(n), 64'(lat(op)));
      chk("signal", Signal, op[2] ? 2'b10 : 2'b01);
      chk("ans", MUTAns, e);
      exp_hold = e;
      @(negedge clk);
      chk("signal_clr", Signal, 0);
      chk("busy_off", Busy, 0);
      if (spam) begin
         wr = 0;
         repeat (40) begin
            @(negedge clk);
            if (Signal != 2'b00) wr++;
         end
         chk("no_extra_wr", 64'(wr), 0);
      end
   endtask

   task automatic cancel_op(input logic [2:0] op, input logic [31:0] a,
                            input logic [31:0] b, input int k);
      int wr;
      Start = 1'b1;
      Op    = op;
      SrcA  = a;
      SrcB  = b;
      wr = 0;
      repeat (k) begin
         @(negedge clk);
         Start = 1'b0;
         if (Signal != 2'b00) wr++;
      end
      Cancel = 1'b1;
      @(negedge clk);
      Cancel = 1'b0;
      chk("cxl_busy", Busy, 0);
      chk("cxl_signal", Signal, 0);
      chk("cxl_ans", MUTAns, exp_hold);
      chk("cxl_wr", 64'(wr), 0);
   endtask

   initial begin
      logic [2:0]  rop;
      logic [31:0] ra, rb;
      rst = 1'b0;
      Start = 1'b0;
      Op = '0;
      SrcA = '0;
      SrcB = '0;
      Cancel = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_busy", Busy, 0);
      chk("rst_signal", Signal, 0);
      chk("rst_ans", MUTAns, 0);
      rst = 1'b1;
      @(negedge clk);

      run_op(3'd0, 32'hFFFF_FFFD, 32'h0000_0005, 0);
      run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
      run_op(3'd2, 32'hFFFF_FFF9, 32'h0000_0002, 0);
      run_op(3'd3, 32'h0000_000A, 32'h0000_0000, 0);
      run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0);
      run_op(3'd2, 32'h8000_0005, 32'h0000_0000, 0);
      run_op(3'd4, 32'h0000_0002, 32'h0000_0003, 1);
      run_op(3'd5, 32'h8000_0001, 32'h0000_0007, 0);

      Start = 1'b1;
      Op = 3'd6;
      @(negedge clk);
      chk("illegal6", Busy, 0);
      Op = 3'd7;
      @(negedge clk);
      Start = 1'b0;
      chk("illegal7", Busy, 0);
      chk("illegal_sig", Signal, 0);

      Start = 1'b1;
      Cancel = 1'b1;
      Op = 3'd1;
      @(negedge clk);
      Start = 1'b0;
      Cancel = 1'b0;
      chk("idle_cxl", Busy, 0);

      cancel_op(3'd3, 32'd1234, 32'd7, 10);
      run_op(3'd0, 32'h0000_1234, 32'hFFFF_FF00, 0);
      cancel_op(3'd2, 32'hFFFF_0000, 32'd9, 33);
      run_op(3'd3, 32'd1000, 32'd33, 0);

      Start = 1'b1;
      Op = 3'd2;
      SrcA = 32'd77;
      SrcB = 32'd5;
      repeat (20) begin
         @(negedge clk);
         Start = 1'b0;
      end
      #2 rst = 1'b0;
      #1;
      chk("arst_busy", Busy, 0);
      chk("arst_signal", Signal, 0);
      chk("arst_ans", MUTAns, 0);
      exp_hold = '0;
      @(negedge clk);
      rst = 1'b1;
      run_op(3'd1, 32'd2, 32'd3, 0);

      repeat (25) begin
         rop = 3'($urandom_range(0, 5));
         ra  = $urandom;
         rb  = $urandom;
         case ($urandom_range(0, 5))
            0: rb = 32'd0;
            1: rb = 32'($urandom_range(1, 9));
            2: ra = 32'h8000_0000;
            3: rb = 32'hFFFF_FFFF;
            default: ;
         endcase
         run_op(rop, ra, rb, 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
